// File: rtl/mem_access_unit_pkg.sv
// Shared encodings, state type and store-merge helper for the data-memory access unit.
package mem_pkg;

    localparam int DEPTH_WORDS_DEF = 100;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Replaces the addressed byte/half lane of the current word with the store data.
    function automatic logic [31:0] merge_store(
        input logic [31:0] word,
        input logic [31:0] wdata,
        input logic [1:0]  lane,
        input logic [1:0]  size
    );
        logic [31:0] r;
        r = word;
        if (size == SZ_BYTE) begin
            r[{lane, 3'b000} +: 8] = wdata[7:0];
        end else if (size == SZ_HALF) begin
            r[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response bus between the MEM stage, the access unit and the word memory.
interface mem_access_unit_if #(
    parameter int AW = 32
);
    logic          req_valid;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;

    logic [31:0]   mem_A;
    logic [31:0]   mem_WD;
    logic          mem_WE;
    logic [31:0]   mem_RD;

    logic [31:0]   load_data;
    logic          done;
    logic          stall;
    logic          fault;
    logic [AW-1:0] fault_addr;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  load_data, done, stall, fault, fault_addr
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_RD,
        output mem_A, mem_WD, mem_WE, load_data, done, stall, fault, fault_addr
    );

    modport mem (
        input  mem_A, mem_WD, mem_WE,
        output mem_RD
    );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Picks the addressed byte/half lane out of a read word and sign- or zero-extends it.
module lane_align
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_lane, 3'b000} +: 8];
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
        o_data = i_word;
        case (i_size)
            SZ_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            default: o_data = i_word;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-organised data memory: sub-word RMW, extension,
// alignment/range faults and pipeline stall.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int AW          = 32
) (
    input  logic              CLK,
    input  logic              reset,
    mem_access_unit_if.slave  bus
);
    state_t        r_state;
    state_t        w_next;
    logic [31:0]   r_load_data;
    logic [31:0]   r_merge;
    logic [31:0]   r_index;
    logic [AW-1:0] r_fault_addr;
    logic          r_fault;

    logic [31:0]   w_idx;
    logic [31:0]   w_ext;
    logic [31:0]   w_merged;
    logic          w_bad;
    logic          w_accept;
    logic          w_load;
    logic          w_wstore;
    logic          w_sstore;
    logic          w_we;
    logic [31:0]   w_A;
    logic [31:0]   w_WD;

    assign w_idx = 32'(bus.req_addr[AW-1:2]);

    assign w_bad = (bus.req_size == SZ_ILLEGAL)
                 | ((bus.req_size == SZ_HALF) & bus.req_addr[0])
                 | ((bus.req_size == SZ_WORD) & (|bus.req_addr[1:0]))
                 | (w_idx >= 32'(DEPTH_WORDS));

    assign w_accept = (r_state == IDLE) & bus.req_valid;
    assign w_load   = ~w_bad & ~bus.req_we;
    assign w_wstore = ~w_bad &  bus.req_we & (bus.req_size == SZ_WORD);
    assign w_sstore = ~w_bad &  bus.req_we & (bus.req_size != SZ_WORD);

    lane_align u_lane_align (
        .i_word     (bus.mem_RD),
        .i_lane     (bus.req_addr[1:0]),
        .i_size     (bus.req_size),
        .i_unsigned (bus.req_unsigned),
        .o_data     (w_ext)
    );

    assign w_merged = merge_store(bus.mem_RD, bus.req_wdata, bus.req_addr[1:0], bus.req_size);

    always_comb begin
        w_next = r_state;
        w_A    = w_idx;
        w_WD   = bus.req_wdata;
        w_we   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (w_sstore) begin
                        w_next = WRITE;
                    end else begin
                        w_next = DONE;
                        w_we   = w_wstore;
                    end
                end
            end
            WRITE: begin
                w_A    = r_index;
                w_WD   = r_merge;
                w_we   = 1'b1;
                w_next = DONE;
            end
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_load_data  <= '0;
            r_merge      <= '0;
            r_index      <= '0;
            r_fault_addr <= '0;
            r_fault      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_fault <= w_bad;
                if (w_bad) begin
                    r_fault_addr <= bus.req_addr;
                end
                if (w_load) begin
                    r_load_data <= w_ext;
                end
                if (w_sstore) begin
                    r_merge <= w_merged;
                    r_index <= w_idx;
                end
            end
        end
    end

    // Write enable and stall are gated by reset so nothing leaks out while it is held low.
    assign bus.mem_A      = w_A;
    assign bus.mem_WD     = w_WD;
    assign bus.mem_WE     = reset & w_we;
    assign bus.load_data  = r_load_data;
    assign bus.fault_addr = r_fault_addr;
    assign bus.done       = (r_state == DONE);
    assign bus.fault      = (r_state == DONE) & r_fault;
    assign bus.stall      = reset & bus.req_valid & (r_state != DONE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised and directed bench for mem_access_unit against a shadow-memory reference model.
module tb_mem_access_unit;

    logic CLK;
    logic reset;

    mem_access_unit_if #(.AW(32)) bus ();

    mem_access_unit #(.DEPTH_WORDS(100), .AW(32)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [31:0] mem     [0:127];
    logic [31:0] ref_mem [0:127];
    logic        bd_we;
    logic [6:0]  bd_idx;
    logic [31:0] bd_data;

    assign bus.mem_RD = (bus.mem_A < 32'd128) ? mem[bus.mem_A[6:0]] : 32'h0;

    always @(posedge CLK) begin
        if (bd_we)
            mem[bd_idx] <= bd_data;
        else if (bus.mem_WE && bus.mem_A < 32'd128)
            mem[bus.mem_A[6:0]] <= bus.mem_WD;
    end

    int          errs;
    int          chks;
    logic [31:0] exp_load;
    logic [31:0] exp_faddr;

    function automatic bit model_bad(input logic [1:0] sz, input logic [31:0] addr);
        return (sz == 2'd3) || (sz == 2'd1 && addr % 2 != 0) ||
               (sz == 2'd2 && addr % 4 != 0) || (addr / 4 >= 100);
    endfunction

    function automatic logic [31:0] model_ext(input logic [31:0] word, input logic [31:0] addr,
                                              input logic [1:0] sz, input logic uns);
        logic [31:0] v;
        int sh;
        sh = 8 * int'(addr % 4);
        if (sz == 2'd0) begin
            v = (word >> sh) & 32'hFF;
            if (!uns && v >= 32'd128) v = v - 32'd256;
        end else if (sz == 2'd1) begin
            v = (word >> sh) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] word, input logic [31:0] wd,
                                                input logic [31:0] addr, input logic [1:0] sz);
        logic [31:0] mask;
        int sh;
        sh   = 8 * int'(addr % 4);
        mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
        return (word & ~mask) | ((wd << sh) & mask);
    endfunction

    task automatic backdoor(input int idx, input logic [31:0] data);
        @(negedge CLK);
        bd_we   = 1'b1;
        bd_idx  = idx[6:0];
        bd_data = data;
        @(posedge CLK);
        #1 bd_we = 1'b0;
        ref_mem[idx] = data;
    endtask

    // Issues one request and checks latency, stall, write activity, result registers and memory.
    task automatic run_req(input bit in_done, input bit keep, input logic we, input logic [1:0] sz,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                           input string nm, output logic [31:0] ld_out);
        logic [31:0] idx, a0, w_a, w_d, e_wd;
        bit bad, stall_bad;
        int lat, e_lat, wecnt, e_wecnt, wecyc, e_wecyc;
        idx   = addr >> 2;
        bad   = model_bad(sz, addr);
        e_lat = (!bad && we && sz != 2'd2) ? 2 : 1;
        e_wecnt = (!bad && we) ? 1 : 0;
        e_wecyc = (sz == 2'd2) ? 0 : 1;
        e_wd  = 32'h0;
        if (bad) exp_faddr = addr;
        else if (!we) exp_load = model_ext(ref_mem[idx], addr, sz, uns);
        else begin
            e_wd = (sz == 2'd2) ? wd : model_merge(ref_mem[idx], wd, addr, sz);
            ref_mem[idx] = e_wd;
        end

        if (!in_done) @(negedge CLK);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
        bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wd;
        if (in_done) begin
            #1;
            chks++;
            if (bus.stall !== 1'b0 || bus.done !== 1'b1) begin
                errs++;
                $display("FAIL %s done-cycle: stall=%0b done=%0b want stall=0 done=1", nm, bus.stall, bus.done);
            end
            @(negedge CLK);
        end

        lat = -1; wecnt = 0; wecyc = -1; stall_bad = 0; a0 = 'x; w_a = 'x; w_d = 'x;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (c == 0) a0 = bus.mem_A;
            if (bus.mem_WE) begin
                wecnt++; wecyc = c; w_a = bus.mem_A; w_d = bus.mem_WD;
            end
            if (bus.done) begin
                lat = c;
                break;
            end
            if (bus.stall !== 1'b1) stall_bad = 1;
            @(negedge CLK);
        end

        chks++;
        if (lat != e_lat) begin
            errs++; $display("FAIL %s latency: got %0d want %0d", nm, lat, e_lat);
        end
        chks++;
        if (bus.fault !== bad) begin
            errs++; $display("FAIL %s fault: got %0b want %0b", nm, bus.fault, bad);
        end
        chks++;
        if (stall_bad || (lat >= 0 && bus.stall !== 1'b0)) begin
            errs++; $display("FAIL %s stall: pre-done low=%0b done-cycle stall=%0b want 0/0", nm, stall_bad, bus.stall);
        end
        chks++;
        if (a0 !== idx) begin
            errs++; $display("FAIL %s mem_A: got %h want %h", nm, a0, idx);
        end
        chks++;
        if (bus.load_data !== exp_load) begin
            errs++; $display("FAIL %s load_data: got %h want %h", nm, bus.load_data, exp_load);
        end
        chks++;
        if (bus.fault_addr !== exp_faddr) begin
            errs++; $display("FAIL %s fault_addr: got %h want %h", nm, bus.fault_addr, exp_faddr);
        end
        chks++;
        if (wecnt != e_wecnt) begin
            errs++; $display("FAIL %s write count: got %0d want %0d", nm, wecnt, e_wecnt);
        end
        if (e_wecnt == 1) begin
            chks++;
            if (wecyc != e_wecyc || w_a !== idx || w_d !== e_wd) begin
                errs++;
                $display("FAIL %s write: cyc=%0d A=%h WD=%h want cyc=%0d A=%h WD=%h",
                         nm, wecyc, w_a, w_d, e_wecyc, idx, e_wd);
            end
        end
        if (idx < 128) begin
            chks++;
            if (mem[idx] !== ref_mem[idx]) begin
                errs++; $display("FAIL %s memory word %0d: got %h want %h", nm, idx, mem[idx], ref_mem[idx]);
            end
        end
        ld_out = bus.load_data;
        if (!keep) bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        chks++;
        if (bus.done !== 1'b0 || bus.fault !== 1'b0 || bus.stall !== 1'b0 || bus.mem_WE !== 1'b0 ||
            bus.load_data !== 32'h0 || bus.fault_addr !== 32'h0) begin
            errs++;
            $display("FAIL reset state: done=%0b fault=%0b stall=%0b we=%0b ld=%h fa=%h want all 0",
                     bus.done, bus.fault, bus.stall, bus.mem_WE, bus.load_data, bus.fault_addr);
        end
    endtask

    task automatic test_load();
        logic [31:0] ld;
        backdoor(2, 32'hDEADBEEF);
        run_req(0, 0, 1'b0, 2'd2, 1'b0, 32'h08, 32'h0, "ld_word", ld);
        chks++;
        if (ld !== 32'hDEADBEEF) begin errs++; $display("FAIL ld_word value: got %h want deadbeef", ld); end
        backdoor(2, 32'h80FF1234);
        run_req(0, 0, 1'b0, 2'd0, 1'b0, 32'h0B, 32'h0, "ld_byte_s", ld);
        chks++;
        if (ld !== 32'hFFFFFF80) begin errs++; $display("FAIL ld_byte_s value: got %h want ffffff80", ld); end
        run_req(0, 0, 1'b0, 2'd0, 1'b1, 32'h0B, 32'h0, "ld_byte_u", ld);
        chks++;
        if (ld !== 32'h00000080) begin errs++; $display("FAIL ld_byte_u value: got %h want 00000080", ld); end
        run_req(0, 0, 1'b0, 2'd1, 1'b0, 32'h0A, 32'h0, "ld_half_s", ld);
        chks++;
        if (ld !== 32'hFFFF80FF) begin errs++; $display("FAIL ld_half_s value: got %h want ffff80ff", ld); end
    endtask

    task automatic test_store();
        logic [31:0] ld;
        backdoor(1, 32'h11223344);
        run_req(0, 0, 1'b1, 2'd0, 1'b0, 32'h05, 32'h000000AB, "st_byte", ld);
        chks++;
        if (mem[1] !== 32'h1122AB44) begin errs++; $display("FAIL st_byte word: got %h want 1122ab44", mem[1]); end
        run_req(0, 0, 1'b1, 2'd2, 1'b0, 32'h0C, 32'h12345678, "st_word", ld);
        chks++;
        if (mem[3] !== 32'h12345678) begin errs++; $display("FAIL st_word word: got %h want 12345678", mem[3]); end
        run_req(0, 0, 1'b1, 2'd1, 1'b0, 32'h06, 32'hCAFE55AA, "st_half_hi", ld);
    endtask

    task automatic test_fault();
        logic [31:0] ld;
        run_req(0, 0, 1'b0, 2'd1, 1'b0, 32'h03, 32'h0, "flt_half", ld);
        chks++;
        if (bus.fault_addr !== 32'h03) begin errs++; $display("FAIL flt_half addr: got %h want 00000003", bus.fault_addr); end
        run_req(0, 0, 1'b0, 2'd2, 1'b0, 32'h190, 32'h0, "flt_range", ld);
        run_req(0, 0, 1'b1, 2'd2, 1'b0, 32'h18C, 32'h5A5A5A5A, "st_last_word", ld);
        run_req(0, 0, 1'b1, 2'd3, 1'b0, 32'h10, 32'hFFFFFFFF, "flt_illegal", ld);
        run_req(0, 0, 1'b1, 2'd2, 1'b0, 32'h12, 32'hFFFFFFFF, "flt_word_mis", ld);
    endtask

    task automatic test_back_to_back();
        logic [31:0] ld;
        for (int i = 0; i < 12; i++) begin
            run_req(i != 0, i != 11, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), 32'($urandom_range(0, 395)), $urandom, "b2b", ld);
        end
    endtask

    task automatic test_random();
        logic [31:0] ld;
        for (int i = 0; i < 80; i++) begin
            run_req(0, 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 32'($urandom_range(0, 419)), $urandom, "rand", ld);
        end
    endtask

    task automatic test_reset_midwrite();
        logic [31:0] ld;
        run_req(0, 0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, "pre_rst_load", ld);
        @(negedge CLK);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd1;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h12; bus.req_wdata = 32'h0000BEEF;
        @(negedge CLK);
        chks++;
        if (bus.mem_WE !== 1'b1) begin errs++; $display("FAIL rst_mid write phase: mem_WE=%0b want 1", bus.mem_WE); end
        reset = 1'b0;
        #1;
        chks++;
        if (bus.mem_WE !== 1'b0 || bus.stall !== 1'b0 || bus.done !== 1'b0 || bus.fault !== 1'b0 ||
            bus.load_data !== 32'h0 || bus.fault_addr !== 32'h0) begin
            errs++;
            $display("FAIL rst_mid outputs: we=%0b stall=%0b done=%0b fault=%0b ld=%h fa=%h want all 0",
                     bus.mem_WE, bus.stall, bus.done, bus.fault, bus.load_data, bus.fault_addr);
        end
        bus.req_valid = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        chks++;
        if (mem[4] !== ref_mem[4]) begin errs++; $display("FAIL rst_mid word 4: got %h want %h", mem[4], ref_mem[4]); end
        reset = 1'b1;
        exp_load  = 32'h0;
        exp_faddr = 32'h0;
        run_req(0, 0, 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, "post_rst_load", ld);
    endtask

    initial begin
        errs = 0; chks = 0;
        exp_load = 32'h0; exp_faddr = 32'h0;
        bd_we = 1'b0; bd_idx = '0; bd_data = '0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        reset = 1'b0;
        for (int i = 0; i < 128; i++) ref_mem[i] = 32'h0;
        test_reset();
        for (int i = 0; i < 128; i++) backdoor(i, $urandom);
        @(negedge CLK);
        reset = 1'b1;
        test_load();
        test_store();
        test_fault();
        test_back_to_back();
        test_random();
        test_reset_midwrite();
        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Pipeline-side initiator for the word-organised data memory (synchronous write, combinational read, word-indexed address).
- Accepts byte-addressed load/store requests from the MEM stage and drives the memory's A/WD/WE port; the read data returns on RD.
- Handles byte, halfword and word sizes, including read-modify-write for sub-word stores.
- Provides sign/zero extension, alignment and range checking, and a stall to the pipeline.

Parameters:
- DEPTH_WORDS, 100: number of implemented memory words; word index >= DEPTH_WORDS is an access fault.
- AW, 32: byte-address width.

Ports:
- CLK  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- req_valid  in  1  request present; held stable by requester while stall=1
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads only: 1 zero-extend, 0 sign-extend
- req_addr  in  AW  byte address
- req_wdata  in  32  store data, right-justified
- mem_A  out  32  word index to memory = addr[31:2]
- mem_WD  out  32  write word
- mem_WE  out  1  write enable
- mem_RD  in  32  combinational read word
- load_data  out  32  registered, extended load result
- done  out  1  one-cycle completion pulse
- stall  out  1  hold pipeline
- fault  out  1  one-cycle pulse with done on misalign/illegal/out-of-range
- fault_addr  out  AW  byte address of last fault

Behaviour:
- Little-endian: byte lane = addr[1:0]; half lane = addr[1].
- Bad request: half with addr[0]=1, word with addr[1:0]!=0, size=11, or addr[31:2] >= DEPTH_WORDS. A bad request performs no memory write and leaves load_data unchanged.
- FSM states: IDLE, WRITE, DONE.
- IDLE (request valid):
  - mem_A = req_addr[31:2].
  - Bad request: latch fault_addr, go to DONE with fault=1.
  - Load: at the edge, register the extracted and extended lane of mem_RD into load_data; go to DONE.
  - Word store: mem_WE=1 and mem_WD=req_wdata combinationally in this cycle; go to DONE.
  - Byte/half store: at the edge, latch the merged word (mem_RD with the target lane replaced by req_wdata[7:0] or [15:0]) and the word index; go to WRITE.
- WRITE: mem_A = latched index, mem_WD = latched merged word, mem_WE=1; go to DONE.
- DONE: done=1 (fault=1 if faulted); go to IDLE. The request present during DONE is treated as consumed and is not re-accepted.
- stall = req_valid & (state != DONE). stall=0 when req_valid=0.
- Latency (request to done): load 1 cycle, word store 1 cycle, sub-word store 2 cycles, fault 1 cycle.
- mem_WE=0 in all states/conditions not listed above. It is forced to 0 while reset is low.
- Extension: byte sign-extends bit 7, half sign-extends bit 15, word is unchanged; req_unsigned zeroes the upper bits.
- Reset (asynchronous, mid-operation included): state goes to IDLE; load_data, fault_addr, and the merge/index registers clear to 0; done, fault and stall go to 0. An in-flight sub-word store is abandoned with no write.
- Back-to-back requests: a new request is sampled in the IDLE cycle following DONE.

Decomposition:
- Shared package mem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILLEGAL
  - state enum {IDLE, WRITE, DONE}
  - DEPTH_WORDS default
- One combinational sub-module, lane_align: given word, addr[1:0], size and unsigned flag, it produces the extended load value. A merge function builds the store word.

Test Plan:
- Load word at 0x08, memory word 2 = 0xDEADBEEF -> mem_A=2, load_data=0xDEADBEEF, done 1 cycle after request, stall high for 1 cycle.
- Load byte at 0x0B, signed, word 2 = 0x80FF_1234 -> load_data=0xFFFFFF80. With unsigned -> 0x00000080. Load half at 0x0A signed -> 0xFFFF80FF.
- Store byte 0xAB to 0x05, word 1 = 0x11223344 -> mem_WE low in IDLE cycle, high in WRITE cycle with mem_A=1, mem_WD=0x1122AB44; done 2 cycles after request.
- Store word 0x12345678 at 0x0C -> mem_WE=1, mem_A=3, mem_WD=0x12345678 in the request cycle; done next cycle; no second write.
- Misaligned half load at 0x03 -> fault=1 with done, fault_addr=0x03, mem_WE never asserted, load_data unchanged. Word at 0x190 (index 100) -> fault.
- Assert reset low during WRITE of a half store -> state IDLE, mem_WE=0, stall=0, target word unmodified, load_data=0.
